// File: rtl/fsk_tone_generator_if.sv
// fsk_tone_generator_if: word handshake between a data source and the FSK tone generator
interface fsk_tone_generator_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;
    modport master (output data_in, data_valid, input data_ready);
    modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/fsk_tone_generator.sv
// fsk_tone_generator: serialises data words LSB first into a phase-continuous two-tone square wave
module fsk_tone_generator #(
    parameter int FREQUENCY0           = 9000,
    parameter int FREQUENCY1           = 11000,
    parameter int CLOCK_FREQUENCY      = 50000000,
    parameter int DATA_WIDTH           = 8,
    parameter int HALF_PERIODS_PER_BIT = 8,
    parameter int GAP_TICKS            = 0
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 enable,
    fsk_tone_generator_if.slave  bus,
    output logic                 sample_out,
    output logic                 busy,
    output logic                 tone_select,
    output logic                 word_done
);
    localparam int HW = $clog2(HALF_PERIODS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [31:0] T0 = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY0));
    localparam logic [31:0] T1 = 32'(CLOCK_FREQUENCY / (2 * FREQUENCY1));
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIODS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_TICKS - 1);

    if (T0 < 2 || T1 < 2 || FREQUENCY1 <= FREQUENCY0 || HALF_PERIODS_PER_BIT < 1) begin : g_param_check
        $error("fsk_tone_generator: invalid tone or timing parameters");
    end

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;
    state_t state, state_n;
    logic [31:0] tick, t_len;
    logic [HW-1:0] half;
    logic [BW-1:0] bit_idx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic accept, period_end, half_last, bit_last, word_end, gap_end;

    assign t_len      = tone_select ? T1 : T0;
    assign period_end = tick == t_len - 32'd1;
    assign half_last  = half == HALF_LAST;
    assign bit_last   = bit_idx == BIT_LAST;
    assign word_end   = state == TONE && period_end && half_last && bit_last;
    assign gap_end    = state == GAP && tick == GAP_LAST;
    assign accept     = bus.data_valid && state == IDLE && enable;
    assign shreg_nx   = shreg >> 1;

    always_ff @(posedge clock or negedge clear)
        if (!clear) state <= IDLE;
        else state <= state_n;

    always_comb
        state_n = !enable ? state :
                  state == IDLE ? (accept ? TONE : IDLE) :
                  state == TONE ? (word_end ? (GAP_TICKS > 0 ? GAP : IDLE) : TONE) :
                  (gap_end ? IDLE : GAP);

    always_comb begin
        bus.data_ready = state == IDLE && enable;
        busy           = state != IDLE;
    end

    // tick doubles as the GAP counter; it is always zero on entry to GAP
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            tick        <= '0;
            half        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            sample_out  <= 1'b0;
            tone_select <= 1'b0;
            word_done   <= 1'b0;
        end else begin
            word_done <= enable && word_end;
            if (accept) begin
                shreg       <= bus.data_in;
                tone_select <= bus.data_in[0];
                tick        <= '0;
                half        <= '0;
                bit_idx     <= '0;
                sample_out  <= ~sample_out;
            end else if (enable && state == TONE) begin
                if (period_end) begin
                    sample_out <= ~sample_out;
                    tick       <= '0;
                    if (!half_last) half <= half + HW'(1);
                    else begin
                        half <= '0;
                        if (!bit_last) begin
                            bit_idx     <= bit_idx + BW'(1);
                            shreg       <= shreg_nx;
                            tone_select <= shreg_nx[0];
                        end
                    end
                end else tick <= tick + 32'd1;
            end else if (enable && state == GAP) tick <= gap_end ? '0 : tick + 32'd1;
        end
    end
endmodule

// File: tb/tb_fsk_tone_generator.sv
// tb_fsk_tone_generator: directed checks of edge timing, reset, freeze and handshake
module tb_fsk_tone_generator;
    logic clock = 1'b0, clear = 1'b1, enable = 1'b1;
    logic so_a, bsy_a, ts_a, wd_a, so_b, bsy_b, ts_b, wd_b;
    fsk_tone_generator_if #(.DATA_WIDTH(4)) bus_a();
    fsk_tone_generator_if #(.DATA_WIDTH(4)) bus_b();

    fsk_tone_generator #(.FREQUENCY0(50), .FREQUENCY1(100), .CLOCK_FREQUENCY(1000), .DATA_WIDTH(4),
                         .HALF_PERIODS_PER_BIT(2), .GAP_TICKS(3)) dut_a (
        .clock(clock), .clear(clear), .enable(enable), .bus(bus_a),
        .sample_out(so_a), .busy(bsy_a), .tone_select(ts_a), .word_done(wd_a));

    fsk_tone_generator #(.FREQUENCY0(50), .FREQUENCY1(100), .CLOCK_FREQUENCY(1000), .DATA_WIDTH(4),
                         .HALF_PERIODS_PER_BIT(2), .GAP_TICKS(0)) dut_b (
        .clock(clock), .clear(clear), .enable(enable), .bus(bus_b),
        .sample_out(so_b), .busy(bsy_b), .tone_select(ts_b), .word_done(wd_b));

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    bit sel = 1'b0;
    logic [3:0] cur = '0;
    int tog[$], wdq[$], acc[$];
    logic ts_log[256], rdy_log[256], bsy_log[256];

    wire so  = sel ? so_b : so_a;
    wire ts  = sel ? ts_b : ts_a;
    wire wd  = sel ? wd_b : wd_a;
    wire bsy = sel ? bsy_b : bsy_a;
    wire rdy = sel ? bus_b.data_ready : bus_a.data_ready;
    wire dv  = sel ? bus_b.data_valid : bus_a.data_valid;

    task automatic drive(input logic v, input logic [3:0] d);
        if (sel) begin bus_b.data_valid = v; bus_b.data_in = d; end
        else begin bus_a.data_valid = v; bus_a.data_in = d; end
    endtask

    task automatic start(input logic [3:0] w);
        int k;
        k = 0;
        @(negedge clock);
        while (rdy !== 1'b1 && k < 100) begin @(negedge clock); k++; end
        n_chk++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL start_ready: data_ready=%b required 1", rdy); end
        cur = w;
        drive(1'b1, w);
    endtask

    // Edge k is the k-th clock edge after the accept edge (edge 0)
    task automatic watch(input int n, input int drop_at, input logic [3:0] nxt,
                         input int off_at, input int off_len, input int pa, input int pb);
        logic prev;
        prev = so;
        tog.delete(); wdq.delete(); acc.delete();
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (so !== prev) tog.push_back(k);
            prev = so;
            if (wd === 1'b1) wdq.push_back(k);
            ts_log[k] = ts; rdy_log[k] = rdy; bsy_log[k] = bsy;
            if (k == 0) cur = nxt;
            drive(k < drop_at || k == pa || k == pb, cur);
            if (k == off_at) enable = 1'b0;
            if (k == off_at + off_len) enable = 1'b1;
            #1;
            if (dv === 1'b1 && rdy === 1'b1) acc.push_back(k + 1);
        end
    endtask

    task automatic test_reset;
        #2 clear = 1'b0;
        #1;
        n_chk += 5;
        if (so_a !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b required 0", so_a); end
        if (bsy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bsy_a); end
        if (ts_a !== 1'b0) begin n_fail++; $display("FAIL reset_tone: got %b required 0", ts_a); end
        if (wd_a !== 1'b0) begin n_fail++; $display("FAIL reset_word_done: got %b required 0", wd_a); end
        if (bus_a.data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_en1: got %b required 1", bus_a.data_ready); end
        enable = 1'b0;
        #1;
        n_chk++;
        if (bus_a.data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_en0: got %b required 0", bus_a.data_ready); end
        enable = 1'b1;
        repeat (2) @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic test_word;
        int e[9];
        int ti[4];
        logic te[4];
        e = '{0, 5, 10, 20, 30, 35, 40, 50, 60};
        ti = '{1, 11, 31, 41};
        te = '{1'b1, 1'b0, 1'b1, 1'b0};
        start(4'b0101);
        watch(70, 0, 4'b0101, -1, 0, -1, -1);
        n_chk++;
        if (tog.size() != 9) begin n_fail++; $display("FAIL word_edge_count: got %0d required 9", tog.size()); end
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if ((i < tog.size() ? tog[i] : -1) != e[i]) begin
                n_fail++; $display("FAIL word_edge[%0d]: got %0d required %0d", i, i < tog.size() ? tog[i] : -1, e[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (ts_log[ti[i]] !== te[i]) begin n_fail++; $display("FAIL word_tone[%0d]: got %b required %b", i, ts_log[ti[i]], te[i]); end
        end
        n_chk += 3;
        if (wdq.size() != 1 || wdq[0] != 60) begin n_fail++; $display("FAIL word_done_edge: got %0d pulses first %0d required 1 at 60", wdq.size(), wdq.size() > 0 ? wdq[0] : -1); end
        if (rdy_log[62] !== 1'b0 || bsy_log[62] !== 1'b1) begin n_fail++; $display("FAIL gap_ready62: ready=%b busy=%b required 0 1", rdy_log[62], bsy_log[62]); end
        if (rdy_log[63] !== 1'b1 || bsy_log[63] !== 1'b0) begin n_fail++; $display("FAIL gap_ready63: ready=%b busy=%b required 1 0", rdy_log[63], bsy_log[63]); end
    endtask

    task automatic test_reset_mid_word;
        start(4'b0101);
        watch(23, 0, 4'b0101, -1, 0, -1, -1);
        @(posedge clock);
        #2 clear = 1'b0;
        #1;
        n_chk += 4;
        if (so_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sample: got %b required 0", so_a); end
        if (bsy_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b required 0", bsy_a); end
        if (wd_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_word_done: got %b required 0", wd_a); end
        if (bus_a.data_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b required 1", bus_a.data_ready); end
        @(negedge clock);
        clear = 1'b1;
        start(4'b1111);
        watch(45, 0, 4'b1111, -1, 0, -1, -1);
        n_chk++;
        if (tog.size() != 9) begin n_fail++; $display("FAIL ones_edge_count: got %0d required 9", tog.size()); end
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if ((i < tog.size() ? tog[i] : -1) != 5 * i) begin
                n_fail++; $display("FAIL ones_edge[%0d]: got %0d required %0d", i, i < tog.size() ? tog[i] : -1, 5 * i);
            end
        end
        n_chk++;
        if (wdq.size() != 1 || wdq[0] != 40) begin n_fail++; $display("FAIL ones_word_done: got %0d pulses first %0d required 1 at 40", wdq.size(), wdq.size() > 0 ? wdq[0] : -1); end
    endtask

    task automatic test_enable_freeze;
        int e[9];
        e = '{0, 5, 10, 27, 37, 42, 47, 57, 67};
        start(4'b0101);
        watch(72, 0, 4'b0101, 13, 7, -1, -1);
        n_chk++;
        if (tog.size() != 9) begin n_fail++; $display("FAIL freeze_edge_count: got %0d required 9", tog.size()); end
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if ((i < tog.size() ? tog[i] : -1) != e[i]) begin
                n_fail++; $display("FAIL freeze_edge[%0d]: got %0d required %0d", i, i < tog.size() ? tog[i] : -1, e[i]);
            end
        end
        n_chk += 3;
        if (rdy_log[14] !== 1'b0) begin n_fail++; $display("FAIL freeze_ready: got %b required 0", rdy_log[14]); end
        if (ts_log[17] !== 1'b0 || bsy_log[17] !== 1'b1) begin n_fail++; $display("FAIL freeze_state: tone=%b busy=%b required 0 1", ts_log[17], bsy_log[17]); end
        if (wdq.size() != 1 || wdq[0] != 67) begin n_fail++; $display("FAIL freeze_word_done: got %0d pulses first %0d required 1 at 67", wdq.size(), wdq.size() > 0 ? wdq[0] : -1); end
    endtask

    task automatic test_back_to_back;
        sel = 1'b1;
        start(4'b0000);
        watch(125, 81, 4'b1111, -1, 0, -1, -1);
        n_chk++;
        if (tog.size() != 18) begin n_fail++; $display("FAIL b2b_edge_count: got %0d required 18", tog.size()); end
        for (int i = 0; i < 18; i++) begin
            n_chk++;
            if ((i < tog.size() ? tog[i] : -1) != (i < 9 ? 10 * i : 81 + 5 * (i - 9))) begin
                n_fail++; $display("FAIL b2b_edge[%0d]: got %0d required %0d", i, i < tog.size() ? tog[i] : -1, i < 9 ? 10 * i : 81 + 5 * (i - 9));
            end
        end
        n_chk += 2;
        if (acc.size() != 1 || acc[0] != 81) begin n_fail++; $display("FAIL b2b_accept: got %0d accepts first %0d required 1 at 81", acc.size(), acc.size() > 0 ? acc[0] : -1); end
        if (wdq.size() != 2 || wdq[0] != 80 || wdq[1] != 121) begin n_fail++; $display("FAIL b2b_word_done: got %0d pulses first %0d required 80 and 121", wdq.size(), wdq.size() > 0 ? wdq[0] : -1); end
        sel = 1'b0;
    endtask

    task automatic test_valid_while_busy;
        int e[9];
        e = '{0, 5, 10, 15, 20, 30, 40, 50, 60};
        start(4'b0011);
        watch(66, 0, 4'b1100, -1, 0, 15, 61);
        n_chk++;
        if (tog.size() != 9) begin n_fail++; $display("FAIL busy_edge_count: got %0d required 9", tog.size()); end
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if ((i < tog.size() ? tog[i] : -1) != e[i]) begin
                n_fail++; $display("FAIL busy_edge[%0d]: got %0d required %0d", i, i < tog.size() ? tog[i] : -1, e[i]);
            end
        end
        n_chk += 3;
        if (acc.size() != 0) begin n_fail++; $display("FAIL busy_accept: got %0d accepts required 0", acc.size()); end
        if (ts_log[21] !== 1'b0 || ts_log[16] !== 1'b1) begin n_fail++; $display("FAIL busy_tone: got %b %b required 1 0", ts_log[16], ts_log[21]); end
        if (wdq.size() != 1) begin n_fail++; $display("FAIL busy_word_done_count: got %0d required 1", wdq.size()); end
    endtask

    initial begin
        bus_a.data_valid = 1'b0; bus_a.data_in = '0;
        bus_b.data_valid = 1'b0; bus_b.data_in = '0;
        test_reset();
        test_word();
        test_reset_mid_word();
        test_enable_freeze();
        test_back_to_back();
        test_valid_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
